// File: rtl/truth_table_sequencer_if.sv
// Datapath vector/result and truth-table row stream bundle for truth_table_sequencer.
// master: sequencer side; slave: datapath + row consumer side.
interface truth_table_sequencer_if #(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned N_OUT = 4
);
    logic [N_IN-1:0]       vec_out;
    logic [N_OUT-1:0]      res_in;
    logic                  row_valid;
    logic                  row_ready;
    logic [N_IN+N_OUT-1:0] row_data;
    logic                  row_last;

    modport master (
        output vec_out, row_valid, row_data, row_last,
        input  res_in, row_ready
    );

    modport slave (
        input  vec_out, row_valid, row_data, row_last,
        output res_in, row_ready
    );
endinterface

// File: rtl/truth_table_sequencer.sv
// Sweeps a combinational datapath through all 2^N_IN vectors and streams {vec, res} rows.
// Optional TTSEQ_SIGNATURE_EN adds a 16-bit rotate-xor signature of all accepted results.
module truth_table_sequencer #(
    parameter int unsigned N_IN          = 4,
    parameter int unsigned N_OUT         = 4,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    output logic busy,
    output logic done,
`ifdef TTSEQ_SIGNATURE_EN
    output logic [15:0] sig,
`endif
    truth_table_sequencer_if.master bus
);

    localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE_CYCLES - 1);
    localparam logic [N_IN:0] LastIdx = {1'b0, {N_IN{1'b1}}};

    typedef enum logic [2:0] {StIdle, StApply, StCapture, StEmit, StDone} state_e;

    state_e                state_q, state_d;
    logic [N_IN:0]         idx_q, idx_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [N_IN+N_OUT-1:0] row_data_q, row_data_d;
    logic                  row_last_q, row_last_d;
    logic                  handshake;

    assign handshake = (state_q == StEmit) && bus.row_ready;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        row_data_d = row_data_q;
        row_last_d = row_last_q;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d = StApply;
                    idx_d   = '0;
                    cnt_d   = CntLoad;
                end
            end
            StApply: begin
                if (cnt_q == '0) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StCapture: begin
                row_data_d = {idx_q[N_IN-1:0], bus.res_in};
                row_last_d = (idx_q == LastIdx);
                state_d    = StEmit;
            end
            StEmit: begin
                if (handshake) begin
                    if (row_last_q) begin
                        state_d = StDone;
                    end else begin
                        state_d = StApply;
                        idx_d   = idx_q + 1'b1;
                        cnt_d   = CntLoad;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                idx_d   = '0;
            end
            default: state_d = StIdle;
        endcase
        // Abort overrides any handshake or start decision made above.
        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
            idx_d   = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            cnt_q      <= '0;
            row_data_q <= '0;
            row_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            row_data_q <= row_data_d;
            row_last_q <= row_last_d;
        end
    end

    always_comb begin
        bus.vec_out = '0;
        if ((state_q == StApply) || (state_q == StCapture) || (state_q == StEmit)) begin
            bus.vec_out = idx_q[N_IN-1:0];
        end
    end

    assign bus.row_valid = (state_q == StEmit);
    assign bus.row_data  = row_data_q;
    assign bus.row_last  = row_last_q;
    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StDone);

`ifdef TTSEQ_SIGNATURE_EN
    logic [15:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (state_q == StIdle) begin
            if (start && !abort) begin
                sig_d = '0;
            end
        end else if (abort) begin
            sig_d = '0;
        end else if (handshake) begin
            sig_d = {sig_q[14:0], sig_q[15]} ^ 16'(row_data_q[N_OUT-1:0]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;
`endif

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Self-checking bench for truth_table_sequencer driving a logic_ops datapath model.
// Covers reset, full sweep, settle timing, stall, abort and (when enabled) the signature.
module tb_truth_table_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, abort = 1'b0, start3 = 1'b0, abort3 = 1'b0;
    logic busy, done, busy3, done3;
`ifdef TTSEQ_SIGNATURE_EN
    logic [15:0] sig, sig3;
`endif
    int total = 0;
    int bad = 0;
    logic [8:0] exp_q[$];

    truth_table_sequencer_if #(.N_IN(4), .N_OUT(4)) bus ();
    truth_table_sequencer_if #(.N_IN(4), .N_OUT(4)) bus3 ();

    always #5 clk = ~clk;

    // logic_ops: a=v[3], b=v[2], c=v[1], d=v[0] -> {a&b, c&d, a|b, ~d}
    function automatic logic [3:0] lops(input logic [3:0] v);
        return {v[3] & v[2], v[1] & v[0], v[3] | v[2], ~v[0]};
    endfunction

    always_comb bus.res_in = lops(bus.vec_out);
    always_comb bus3.res_in = lops(bus3.vec_out);

    truth_table_sequencer #(.N_IN(4), .N_OUT(4), .SETTLE_CYCLES(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .busy  (busy),
        .done  (done),
`ifdef TTSEQ_SIGNATURE_EN
        .sig   (sig),
`endif
        .bus   (bus)
    );

    truth_table_sequencer #(.N_IN(4), .N_OUT(4), .SETTLE_CYCLES(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start3),
        .abort (abort3),
        .busy  (busy3),
        .done  (done3),
`ifdef TTSEQ_SIGNATURE_EN
        .sig   (sig3),
`endif
        .bus   (bus3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.row_ready = 1'b1;
        bus3.row_ready = 1'b1;
        repeat (3) tick();
        total++;
        if ({busy, done, bus.row_valid, bus.row_last} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 0000", {busy, done, bus.row_valid, bus.row_last});
        end
        total++;
        if (bus.vec_out !== 4'h0) begin
            bad++;
            $display("FAIL reset_vec: got %h want 0", bus.vec_out);
        end
        total++;
        if (bus.row_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_data: got %h want 00", bus.row_data);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0 || busy3 !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got busy=%b busy3=%b want 0 0", busy, busy3);
        end
    endtask

    task automatic test_logic_ops();
        int rows, dones, last_hs, done_cyc, c;
        logic [8:0] e;
        logic [7:0] r5, r15;
        logic l15;
        bit fin;
        rows = 0; dones = 0; last_hs = -10; done_cyc = -1; fin = 0;
        r5 = '0; r15 = '0; l15 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back({(i == 15), 4'(i), lops(4'(i))});
        end
        bus.row_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (c = 0; c < 200 && !fin; c++) begin
            start = (c == 10);  // pulse while busy; must be ignored
            if (c == 10) begin
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL busy_mid_sweep: got %b want 1", busy);
                end
            end
            if (bus.row_valid === 1'b1) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1ff;
                total++;
                if ({bus.row_last, bus.row_data} !== e) begin
                    bad++;
                    $display("FAIL row: got last=%b data=%h want last=%b data=%h",
                             bus.row_last, bus.row_data, e[8], e[7:0]);
                end
                if (bus.row_data[7:4] == 4'd5) r5 = bus.row_data;
                if (bus.row_data[7:4] == 4'hf) begin
                    r15 = bus.row_data;
                    l15 = bus.row_last;
                end
                rows++;
                last_hs = c;
            end
            if (done === 1'b1) begin
                dones++;
                done_cyc = c;
            end
            if (dones > 0 && busy === 1'b0 && done === 1'b0) fin = 1;
            else tick();
        end
        start = 1'b0;
        total++;
        if (!fin) begin
            bad++;
            $display("FAIL sweep_timeout: got running want finished");
        end
        total++;
        if (rows != 16 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL row_count: got %0d rows, %0d left want 16, 0", rows, exp_q.size());
        end
        total++;
        if (dones != 1 || done_cyc != last_hs + 1) begin
            bad++;
            $display("FAIL done_pulse: got %0d pulses at %0d want 1 at %0d",
                     dones, done_cyc, last_hs + 1);
        end
        total++;
        if (r5 !== 8'h52) begin
            bad++;
            $display("FAIL row5: got %h want 52", r5);
        end
        total++;
        if ({l15, r15} !== 9'h1fe) begin
            bad++;
            $display("FAIL row15: got last=%b data=%h want last=1 data=fe", l15, r15);
        end
        exp_q.delete();
    endtask

    task automatic test_settle3();
        int n, first, last_n, nrows, run;
        logic [3:0] prev;
        first = -1; last_n = 0; nrows = 0; run = 1;
        prev = bus3.vec_out;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        n = 1;
        while (n < 80 && nrows < 4) begin
            if (bus3.vec_out == prev) run++;
            else run = 1;
            prev = bus3.vec_out;
            if (bus3.row_valid === 1'b1) begin
                if (first < 0) begin
                    first = n;
                end else begin
                    total++;
                    if (n - last_n != 5 || run != 5) begin
                        bad++;
                        $display("FAIL settle_spacing: got gap=%0d hold=%0d want 5 5",
                                 n - last_n, run);
                    end
                end
                total++;
                if (bus3.row_data !== {bus3.vec_out, lops(bus3.vec_out)} ||
                    bus3.vec_out !== 4'(nrows)) begin
                    bad++;
                    $display("FAIL settle_row: got %h want %h", bus3.row_data,
                             {4'(nrows), lops(4'(nrows))});
                end
                last_n = n;
                nrows++;
            end
            if (nrows < 4) begin
                tick();
                n++;
            end
        end
        total++;
        if (first != 5) begin
            bad++;
            $display("FAIL settle_first: got %0d want 5", first);
        end
        abort3 = 1'b1;
        tick();
        abort3 = 1'b0;
        total++;
        if (busy3 !== 1'b0) begin
            bad++;
            $display("FAIL settle_abort: got busy=%b want 0", busy3);
        end
    endtask

    task automatic test_stall_abort();
        int k, seen;
        bus.row_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (k < 100 && !(bus.vec_out == 4'd7 && bus.row_valid === 1'b0)) begin
            tick();
            k++;
        end
        bus.row_ready = 1'b0;
        k = 0;
        while (k < 10 && bus.row_valid !== 1'b1) begin
            tick();
            k++;
        end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (bus.row_valid !== 1'b1 || bus.row_data !== 8'h76 || bus.vec_out !== 4'd7) begin
                bad++;
                $display("FAIL stall: got v=%b data=%h vec=%h want 1 76 7",
                         bus.row_valid, bus.row_data, bus.vec_out);
            end
            tick();
        end
        bus.row_ready = 1'b1;
        tick();
        total++;
        if (bus.row_valid !== 1'b0 || bus.vec_out !== 4'd8) begin
            bad++;
            $display("FAIL stall_release: got v=%b vec=%h want 0 8", bus.row_valid, bus.vec_out);
        end
        k = 0;
        while (k < 20 && bus.vec_out != 4'd9) begin
            tick();
            k++;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if ({busy, done, bus.row_valid} !== 3'b000 || bus.vec_out !== 4'd0) begin
            bad++;
            $display("FAIL abort: got busy=%b done=%b v=%b vec=%h want 0 0 0 0",
                     busy, done, bus.row_valid, bus.vec_out);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.row_valid === 1'b1 || done === 1'b1 || busy === 1'b1) seen++;
            tick();
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL abort_quiet: got %0d active cycles want 0", seen);
        end
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL start_abort_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid_emit();
        int k;
        bus.row_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (k < 50 && !(bus.vec_out == 4'd3 && bus.row_valid === 1'b0)) begin
            tick();
            k++;
        end
        bus.row_ready = 1'b0;
        k = 0;
        while (k < 10 && bus.row_valid !== 1'b1) begin
            tick();
            k++;
        end
        total++;
        if (bus.row_data !== 8'h34) begin
            bad++;
            $display("FAIL pre_reset_row: got %h want 34", bus.row_data);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, bus.row_valid, bus.row_last} !== 4'b0000 ||
            bus.row_data !== 8'h00 || bus.vec_out !== 4'h0) begin
            bad++;
            $display("FAIL async_reset: got ctrl=%b data=%h vec=%h want 0000 00 0",
                     {busy, done, bus.row_valid, bus.row_last}, bus.row_data, bus.vec_out);
        end
        tick();
        rst_n = 1'b1;
        bus.row_ready = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (k < 10 && bus.row_valid !== 1'b1) begin
            tick();
            k++;
        end
        total++;
        if (bus.row_valid !== 1'b1 || bus.row_data !== 8'h01) begin
            bad++;
            $display("FAIL restart_row0: got v=%b data=%h want 1 01", bus.row_valid, bus.row_data);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

`ifdef TTSEQ_SIGNATURE_EN
    task automatic test_signature();
        logic [15:0] ref_sig;
        int k;
        ref_sig = '0;
        for (int i = 0; i < 16; i++) begin
            ref_sig = {ref_sig[14:0], ref_sig[15]} ^ {12'h000, lops(4'(i))};
        end
        bus.row_ready = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            k = 0;
            while (k < 100 && done !== 1'b1) begin
                tick();
                k++;
            end
            tick();
            total++;
            if (sig !== ref_sig) begin
                bad++;
                $display("FAIL signature pass %0d: got %h want %h", pass, sig, ref_sig);
            end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if (sig !== 16'h0000) begin
            bad++;
            $display("FAIL signature_abort: got %h want 0000", sig);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_logic_ops();
        test_settle3();
        test_stall_abort();
        test_reset_mid_emit();
`ifdef TTSEQ_SIGNATURE_EN
        test_signature();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
